// File: rtl/am2950_fifo_port_if.sv
// Control and status bundle of the am2950 buffered bus port.
// The tristate buses a/b stay plain inout ports on the module itself.
interface am2950_fifo_port_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          a_we;
    logic          a_oe;
    logic          a_rd;
    logic          b_we;
    logic          b_oe;
    logic          b_rd;
    logic          err_clr;

    logic [CW-1:0] ab_cnt;
    logic [CW-1:0] ba_cnt;
    logic          ab_full;
    logic          ab_empty;
    logic          ba_full;
    logic          ba_empty;
    logic          ab_ovf;
    logic          ab_udf;
    logic          ba_ovf;
    logic          ba_udf;
    logic          a_cont;
    logic          b_cont;

    modport master (
        output a_we, a_oe, a_rd, b_we, b_oe, b_rd, err_clr,
        input  ab_cnt, ba_cnt, ab_full, ab_empty, ba_full, ba_empty,
               ab_ovf, ab_udf, ba_ovf, ba_udf, a_cont, b_cont
    );

    modport slave (
        input  a_we, a_oe, a_rd, b_we, b_oe, b_rd, err_clr,
        output ab_cnt, ba_cnt, ab_full, ab_empty, ba_full, ba_empty,
               ab_ovf, ab_udf, ba_ovf, ba_udf, a_cont, b_cont
    );
endinterface

// File: rtl/am2950_fifo_port.sv
// Buffered bidirectional port between tristate buses A and B.
// Two independent DEPTH-entry FIFOs: AB (A writes, B reads) and BA (B writes,
// A reads). Index AB/BA below selects the FIFO; the push side of FIFO AB is
// side A, so a_cont lives at index AB and b_cont at index BA.
module am2950_fifo_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [WIDTH-1:0]  a,
    inout  wire  [WIDTH-1:0]  b,
    am2950_fifo_port_if.slave ctl
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int AB = 0;
    localparam int BA = 1;

    // Request decode per FIFO
    logic [1:0]       we;
    logic [1:0]       oe;
    logic [1:0]       rd;
    logic [WIDTH-1:0] din [2];

    assign we      = {ctl.b_we, ctl.a_we};
    assign oe      = {ctl.b_oe, ctl.a_oe};
    assign rd      = {ctl.a_rd, ctl.b_rd};
    assign din[AB] = a;
    assign din[BA] = b;

    // Storage and state
    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    wr_ptr_d [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [PW-1:0]    rd_ptr_d [2];
    logic [CW-1:0]    cnt_q    [2];
    logic [CW-1:0]    cnt_d    [2];
    logic [1:0]       ovf_q, ovf_d;
    logic [1:0]       udf_q, udf_d;
    logic [1:0]       cont_q, cont_d;

    logic [1:0]       empty, full;
    logic [1:0]       push_try, push_ok, pop_ok;
    logic [1:0]       ovf_evt, udf_evt, cont_evt;
    logic [WIDTH-1:0] head [2];

    // Next-state logic: push/pop arbitration, counts and sticky errors
    always_comb begin
        // NOTE: every output of this block is assigned on every pass of the
        // loop, so no path leaves a value unassigned and no latch is inferred.
        for (int d = 0; d < 2; d++) begin
            empty[d]    = (cnt_q[d] == '0);
            full[d]     = (cnt_q[d] == CW'(DEPTH));
            push_try[d] = we[d] && !oe[d];
            pop_ok[d]   = rd[d] && !empty[d];
            // A pop in the same cycle frees a slot, so a full FIFO still accepts.
            push_ok[d]  = push_try[d] && (!full[d] || pop_ok[d]);
            ovf_evt[d]  = push_try[d] && full[d] && !pop_ok[d];
            udf_evt[d]  = rd[d] && empty[d];
            cont_evt[d] = we[d] && oe[d];

            wr_ptr_d[d] = push_ok[d] ? wr_ptr_q[d] + PW'(1) : wr_ptr_q[d];
            rd_ptr_d[d] = pop_ok[d]  ? rd_ptr_q[d] + PW'(1) : rd_ptr_q[d];
            cnt_d[d]    = cnt_q[d] + CW'(push_ok[d]) - CW'(pop_ok[d]);

            // A new event beats a simultaneous clear.
            ovf_d[d]    = ovf_evt[d]  || (ovf_q[d]  && !ctl.err_clr);
            udf_d[d]    = udf_evt[d]  || (udf_q[d]  && !ctl.err_clr);
            cont_d[d]   = cont_evt[d] || (cont_q[d] && !ctl.err_clr);

            head[d]     = mem_q[d][rd_ptr_q[d]];
        end
    end

    // FIFO RAM write port
    // NOTE: the RAM has no reset; empty is tracked by the counts, so stale
    // words are unreachable and clearing them would only cost logic.
    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && push_ok[d]) begin
                mem_q[d][wr_ptr_q[d]] <= din[d];
            end
        end
    end

    // Pointer, count and error registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values computed above, independent of statement order.
        if (rst) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            cnt_q    <= '{default: '0};
            ovf_q    <= '0;
            udf_q    <= '0;
            cont_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            cont_q   <= cont_d;
        end
    end

    // Bus drivers: only a non-empty FIFO ever drives, so stale data never leaks
    assign a = (ctl.a_oe && !empty[BA]) ? head[BA] : {WIDTH{1'bz}};
    assign b = (ctl.b_oe && !empty[AB]) ? head[AB] : {WIDTH{1'bz}};

    // Status outputs
    assign ctl.ab_cnt   = cnt_q[AB];
    assign ctl.ba_cnt   = cnt_q[BA];
    assign ctl.ab_full  = full[AB];
    assign ctl.ab_empty = empty[AB];
    assign ctl.ba_full  = full[BA];
    assign ctl.ba_empty = empty[BA];
    assign ctl.ab_ovf   = ovf_q[AB];
    assign ctl.ab_udf   = udf_q[AB];
    assign ctl.ba_ovf   = ovf_q[BA];
    assign ctl.ba_udf   = udf_q[BA];
    assign ctl.a_cont   = cont_q[AB];
    assign ctl.b_cont   = cont_q[BA];
endmodule
